// File: rtl/ysyx_24070014_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle NPC control path.
// Select codes match the datapath muxes in ImmGen, ALU, WB and PC.
package ysyx_24070014_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_U    = 3'd5;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_OP  = 2'd1;
  localparam logic [1:0] ALU_OPI = 2'd2;
  localparam logic [1:0] ALU_BR  = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] PC_4    = 2'd0;
  localparam logic [1:0] PC_IMM  = 2'd1;
  localparam logic [1:0] PC_JALR = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic       a_pc;
    logic       b_imm;
    logic [1:0] alu_mode;
    logic [1:0] wb_sel;
    logic [1:0] pc_sel;
    logic       rf_wen;
    logic       is_branch;
    logic       is_mem;
    logic       is_store;
  } ctrl_t;

endpackage

// File: rtl/ysyx_24070014_ctrl_decoder.sv
// Combinational RV32I decode of the instruction register into a
// control word, plus illegal and ebreak flags.
module ysyx_24070014_ctrl_decoder
  import ysyx_24070014_ctrl_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic [31:0] inst,
  output ctrl_t       ctl,
  output logic        illegal,
  output logic        ebreak
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       legal;
  logic       is_shift;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign ebreak   = (inst == EBREAK);
  assign illegal  = !ebreak && !legal;
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    ctl   = '0;
    legal = 1'b0;
    unique case (1'b1)
      opc == OPC_LUI: begin
        legal       = 1'b1;
        ctl.imm_sel = IMM_U;
        ctl.wb_sel  = WB_IMM;
        ctl.rf_wen  = 1'b1;
      end
      opc == OPC_AUIPC: begin
        legal       = 1'b1;
        ctl.imm_sel = IMM_U;
        ctl.a_pc    = 1'b1;
        ctl.b_imm   = 1'b1;
        ctl.rf_wen  = 1'b1;
      end
      opc == OPC_JAL: begin
        legal       = 1'b1;
        ctl.imm_sel = IMM_J;
        ctl.pc_sel  = PC_IMM;
        ctl.wb_sel  = WB_PC4;
        ctl.rf_wen  = 1'b1;
      end
      opc == OPC_JALR: begin
        legal       = (f3 == 3'b000);
        ctl.imm_sel = IMM_I;
        ctl.b_imm   = 1'b1;
        ctl.pc_sel  = PC_JALR;
        ctl.wb_sel  = WB_PC4;
        ctl.rf_wen  = 1'b1;
      end
      opc == OPC_BRANCH: begin
        legal         = (f3 != 3'b010) && (f3 != 3'b011);
        ctl.imm_sel   = IMM_B;
        ctl.alu_mode  = ALU_BR;
        ctl.is_branch = 1'b1;
      end
      opc == OPC_LOAD: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010,
                           3'b100, 3'b101};
        ctl.imm_sel = IMM_I;
        ctl.b_imm   = 1'b1;
        ctl.wb_sel  = WB_MEM;
        ctl.rf_wen  = 1'b1;
        ctl.is_mem  = 1'b1;
      end
      opc == OPC_STORE: begin
        legal        = (f3 <= 3'b010);
        ctl.imm_sel  = IMM_S;
        ctl.b_imm    = 1'b1;
        ctl.is_mem   = 1'b1;
        ctl.is_store = 1'b1;
      end
      opc == OPC_OPIMM: begin
        // shamt[5] only exists on a 64-bit datapath
        legal = !(WORD_LEN == 32 && is_shift && inst[25]);
        ctl.imm_sel  = IMM_I;
        ctl.b_imm    = 1'b1;
        ctl.alu_mode = ALU_OPI;
        ctl.rf_wen   = 1'b1;
      end
      opc == OPC_OP: begin
        legal        = 1'b1;
        ctl.alu_mode = ALU_OP;
        ctl.rf_wen   = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_24070014_exec_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core.
// Holds IR, branch outcome and the memory-wait watchdog.
module ysyx_24070014_exec_ctrl
  import ysyx_24070014_ctrl_pkg::*;
#(
  parameter int          WORD_LEN = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_mode,
  input  logic        br_cond,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_rvalid,
  output logic        rf_wen,
  output logic [1:0]  wb_sel,
  output logic        pc_wen,
  output logic [1:0]  pc_sel,
  output logic        halt,
  output logic        err
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic [31:0] wdog_q;
  logic        br_taken_q;
  logic        err_q, err_d;

  ctrl_t ctl;
  logic  illegal;
  logic  ebreak;
  logic  in_fetch;
  logic  in_mem;
  logic  waiting;
  logic  expire;
  logic  active;

  ysyx_24070014_ctrl_decoder #(
    .WORD_LEN(WORD_LEN)
  ) u_dec (
    .inst   (ir_q),
    .ctl    (ctl),
    .illegal(illegal),
    .ebreak (ebreak)
  );

  assign in_fetch = (state_q == S_FETCH);
  assign in_mem   = (state_q == S_MEM);
  assign waiting  = (in_fetch && !ifu_rvalid)
                 || (in_mem && !lsu_rvalid);
  // fires on the TIMEOUT-th waiting cycle; a valid in it wins
  assign expire   = (TIMEOUT != 0)
                 && (wdog_q + 32'd1 == TIMEOUT);
  assign active   = (state_q == S_DECODE)
                 || (state_q == S_EXEC)
                 || in_mem
                 || (state_q == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q       <= NOP;
      wdog_q     <= '0;
      br_taken_q <= 1'b0;
    end else begin
      if (in_fetch && ifu_rvalid)
        ir_q <= ifu_rdata;
      if (waiting)
        wdog_q <= wdog_q + 32'd1;
      else
        wdog_q <= '0;
      if (state_q == S_EXEC)
        br_taken_q <= ctl.is_branch & br_cond;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    ifu_req   = 1'b0;
    lsu_req   = 1'b0;
    lsu_wen   = 1'b0;
    rf_wen    = 1'b0;
    pc_wen    = 1'b0;
    imm_sel   = IMM_NONE;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_mode  = ALU_ADD;
    wb_sel    = WB_ALU;
    pc_sel    = PC_4;

    unique case (state_q)
      S_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_rvalid) begin
          state_d = S_DECODE;
        end else if (expire) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_DECODE: begin
        if (ebreak) begin
          state_d = S_HALT;
        end else if (illegal) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = ctl.is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = ctl.is_store;
        if (lsu_rvalid) begin
          state_d = S_WB;
        end else if (expire) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WB: begin
        pc_wen  = 1'b1;
        rf_wen  = ctl.rf_wen;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (active) begin
      imm_sel   = ctl.imm_sel;
      alu_a_sel = ctl.a_pc;
      alu_b_sel = ctl.b_imm;
      alu_mode  = ctl.alu_mode;
      wb_sel    = ctl.wb_sel;
      if (ctl.is_branch)
        pc_sel = br_taken_q ? PC_IMM : PC_4;
      else
        pc_sel = ctl.pc_sel;
    end

    if (rst) begin
      ifu_req   = 1'b0;
      lsu_req   = 1'b0;
      lsu_wen   = 1'b0;
      rf_wen    = 1'b0;
      pc_wen    = 1'b0;
      imm_sel   = IMM_NONE;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_mode  = ALU_ADD;
      wb_sel    = WB_ALU;
      pc_sel    = PC_4;
    end
  end

  assign inst = rst ? 32'd0 : ir_q;
  assign halt = !rst && (state_q == S_HALT);
  assign err  = !rst && err_q;

endmodule

// File: tb/tb_ysyx_24070014_exec_ctrl.sv
// Directed bench for the NPC exec control FSM.
// Inputs change on the falling edge; outputs are checked there too.
module tb_ysyx_24070014_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic [2:0]  imm_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  alu_mode;
  logic        br_cond;
  logic        lsu_req;
  logic        lsu_wen;
  logic        lsu_rvalid;
  logic        rf_wen;
  logic [1:0]  wb_sel;
  logic        pc_wen;
  logic [1:0]  pc_sel;
  logic        halt;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_24070014_exec_ctrl #(
    .WORD_LEN(32),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ifu_req   (ifu_req),
    .ifu_rvalid(ifu_rvalid),
    .ifu_rdata (ifu_rdata),
    .inst      (inst),
    .imm_sel   (imm_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_mode  (alu_mode),
    .br_cond   (br_cond),
    .lsu_req   (lsu_req),
    .lsu_wen   (lsu_wen),
    .lsu_rvalid(lsu_rvalid),
    .rf_wen    (rf_wen),
    .wb_sel    (wb_sel),
    .pc_wen    (pc_wen),
    .pc_sel    (pc_sel),
    .halt      (halt),
    .err       (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] ins);
    ifu_rdata  = ins;
    ifu_rvalid = 1'b1;
    tick();
    ifu_rvalid = 1'b0;
  endtask

  task automatic mem_wait(input int n, input logic wen);
    for (int i = 0; i < n; i++) begin
      check("mem_req", lsu_req, 1);
      check("mem_wen", lsu_wen, wen);
      if (i == n - 1) lsu_rvalid = 1'b1;
      tick();
      lsu_rvalid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout got 1 exp 0");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst        = 1'b1;
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    lsu_rvalid = 1'b0;
    br_cond    = 1'b0;
    repeat (2) tick();
    check("rst_ifu_req", ifu_req, 0);
    check("rst_inst", inst, 0);
    check("rst_halt", halt, 0);
    check("rst_pc_wen", pc_wen, 0);
    rst = 1'b0;
    #1;
    check("rel_ifu_req", ifu_req, 1);
    check("rel_inst", inst, 32'h13);

    // addi x1, x0, 5
    fetch(32'h0050_0093);
    check("addi_inst", inst, 32'h0050_0093);
    check("addi_imm", imm_sel, 1);
    check("addi_bsel", alu_b_sel, 1);
    check("addi_mode", alu_mode, 2);
    check("addi_dec_rf", rf_wen, 0);
    tick();
    check("addi_ex_req", ifu_req, 0);
    check("addi_ex_pc", pc_wen, 0);
    tick();
    check("addi_wb_rf", rf_wen, 1);
    check("addi_wb_pc", pc_wen, 1);
    check("addi_wb_psel", pc_sel, 0);
    check("addi_wb_wsel", wb_sel, 0);
    tick();
    check("addi_next_req", ifu_req, 1);
    check("addi_next_pc", pc_wen, 0);

    // lw x2, 0(x1), three MEM cycles
    fetch(32'h0000_A103);
    check("lw_imm", imm_sel, 1);
    check("lw_wsel", wb_sel, 1);
    tick();
    check("lw_ex_lsu", lsu_req, 0);
    tick();
    mem_wait(3, 1'b0);
    check("lw_wb_rf", rf_wen, 1);
    check("lw_wb_pc", pc_wen, 1);
    check("lw_wb_lsu", lsu_req, 0);
    check("lw_wb_wsel", wb_sel, 1);
    tick();

    // sw x2, 0(x1)
    fetch(32'h0020_A023);
    check("sw_imm", imm_sel, 2);
    tick();
    tick();
    mem_wait(1, 1'b1);
    check("sw_wb_rf", rf_wen, 0);
    check("sw_wb_pc", pc_wen, 1);
    tick();

    // beq taken, then not taken
    br_cond = 1'b1;
    fetch(32'h0000_0463);
    check("beq_imm", imm_sel, 3);
    check("beq_mode", alu_mode, 3);
    tick();
    tick();
    check("beq_t_psel", pc_sel, 1);
    check("beq_t_rf", rf_wen, 0);
    check("beq_t_pc", pc_wen, 1);
    tick();
    br_cond = 1'b0;
    fetch(32'h0000_0463);
    tick();
    tick();
    check("beq_n_psel", pc_sel, 0);
    check("beq_n_rf", rf_wen, 0);
    check("beq_n_pc", pc_wen, 1);
    tick();

    // jalr x1, 0(x1)
    fetch(32'h0000_80E7);
    check("jalr_imm", imm_sel, 1);
    tick();
    tick();
    check("jalr_psel", pc_sel, 2);
    check("jalr_wsel", wb_sel, 2);
    check("jalr_rf", rf_wen, 1);
    tick();

    // jal x0, 0
    fetch(32'h0000_006F);
    check("jal_imm", imm_sel, 4);
    tick();
    tick();
    check("jal_psel", pc_sel, 1);
    check("jal_wsel", wb_sel, 2);
    tick();

    // valid on the 8th waiting cycle still wins
    repeat (7) tick();
    check("wd_edge_req", ifu_req, 1);
    fetch(32'h0050_0093);
    check("wd_edge_halt", halt, 0);
    check("wd_edge_imm", imm_sel, 1);
    tick();
    tick();
    check("wd_edge_pc", pc_wen, 1);
    tick();

    // fetch timeout after 8 cycles
    for (int i = 0; i < 8; i++) begin
      check("wd_req", ifu_req, 1);
      check("wd_halt", halt, 0);
      tick();
    end
    check("wd_halt_set", halt, 1);
    check("wd_err", err, 1);
    check("wd_halt_req", ifu_req, 0);
    ifu_rvalid = 1'b1;
    repeat (2) tick();
    ifu_rvalid = 1'b0;
    check("wd_persist", halt, 1);
    do_reset();
    check("wd_rst_halt", halt, 0);
    check("wd_rst_err", err, 0);
    check("wd_rst_req", ifu_req, 1);

    // ebreak
    fetch(32'h0010_0073);
    check("ebk_dec_halt", halt, 0);
    tick();
    check("ebk_halt", halt, 1);
    check("ebk_err", err, 0);
    check("ebk_pc", pc_wen, 0);
    check("ebk_req", ifu_req, 0);
    do_reset();

    // illegal instruction
    fetch(32'hFFFF_FFFF);
    tick();
    check("ill_halt", halt, 1);
    check("ill_err", err, 1);
    repeat (3) tick();
    check("ill_persist", halt, 1);
    do_reset();

    // reset while in MEM, late lsu_rvalid ignored
    fetch(32'h0000_A103);
    tick();
    tick();
    check("rm_req", lsu_req, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rm_rst_lsu", lsu_req, 0);
    check("rm_rst_rf", rf_wen, 0);
    check("rm_rst_pc", pc_wen, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rm_fetch", ifu_req, 1);
    check("rm_no_lsu", lsu_req, 0);
    lsu_rvalid = 1'b1;
    tick();
    lsu_rvalid = 1'b0;
    check("rm_late_req", ifu_req, 1);
    check("rm_late_rf", rf_wen, 0);
    check("rm_late_pc", pc_wen, 0);

    // MEM timeout
    fetch(32'h0000_A103);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check("mwd_req", lsu_req, 1);
      tick();
    end
    check("mwd_halt", halt, 1);
    check("mwd_err", err, 1);
    check("mwd_lsu", lsu_req, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24070014_exec_ctrl.md
# ysyx_24070014_exec_ctrl

Multi-cycle control FSM for the NPC core. It sequences each instruction through fetch, decode, execute, memory and write-back. It holds the instruction register and drives the datapath selects: `imm_sel` for `ysyx_24070014_ImmGen`, ALU operand/mode selects, PC and register-file write enables. It performs the req/valid handshakes with the instruction and data memories and traps on `ebreak`, illegal instructions or memory timeout.

## Interface
- `WORD_LEN`, 32: datapath width (32 or 64). Affects only illegal-opcode checks; RV32I decode either way.
- `TIMEOUT`, 255: maximum wait cycles in FETCH/MEM before trapping; 0 disables the watchdog.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ifu_req`  out  1  instruction fetch request.
- `ifu_rvalid`  in  1  fetch data valid.
- `ifu_rdata`  in  32  fetched instruction.
- `inst`  out  32  instruction register (IR).
- `imm_sel`  out  3  0 none, 1 I, 2 S, 3 B, 4 J, 5 U.
- `alu_a_sel`  out  1  0 rs1, 1 pc.
- `alu_b_sel`  out  1  0 rs2, 1 imm.
- `alu_mode`  out  2  0 ADD, 1 OP (funct3/funct7), 2 OP-IMM, 3 branch compare.
- `br_cond`  in  1  ALU compare result, sampled in EXEC.
- `lsu_req`  out  1  data memory request.
- `lsu_wen`  out  1  1 = store.
- `lsu_rvalid`  in  1  data access complete.
- `rf_wen`  out  1  register write strobe.
- `wb_sel`  out  2  0 ALU, 1 load data, 2 pc+4, 3 imm.
- `pc_wen`  out  1  PC update strobe.
- `pc_sel`  out  2  0 pc+4, 1 pc+imm, 2 (ALU result)&~1.
- `halt`  out  1  core stopped.
- `err`  out  1  halt cause was illegal instruction or timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - `ifu_req`=1.
  - On `ifu_rvalid`, IR←`ifu_rdata`, then go to DECODE.
- DECODE (1 cycle):
  - Illegal instruction → HALT with `err`=1.
  - `0x00100073` (ebreak) → HALT with `err`=0.
  - Otherwise → EXEC.
- EXEC (1 cycle):
  - Latch `br_taken`←`br_cond` for branches.
  - Load/store → MEM; otherwise → WB.
- MEM: `lsu_req`=1, `lsu_wen`=store; on `lsu_rvalid` → WB.
- WB (1 cycle): `pc_wen`=1, `rf_wen` per class, then → FETCH.
- HALT: absorbing until `rst`; `halt`=1, all strobes/requests 0.
- Decode by opcode:
  - LUI: U, wb 3.
  - AUIPC: U, a=pc, b=imm, ADD, wb 0.
  - JAL: J, pc_sel 1, wb 2.
  - JALR (funct3 000): I, b=imm, ADD, pc_sel 2, wb 2.
  - BRANCH (funct3 ≠ 010/011): B, mode 3, pc_sel = `br_taken` ? 1 : 0, no rf write.
  - LOAD (funct3 ∈ {000,001,010,100,101}): I, b=imm, ADD, wb 1.
  - STORE (funct3 ∈ {000,001,010}): S, b=imm, ADD, no rf write.
  - OP-IMM: I, b=imm, mode 2.
  - OP: imm_sel 0, mode 1.
  - Everything else, including SYSTEM other than ebreak: illegal.
- `rd`=x0 writes are not filtered here; the register file ignores them.
- Decoded outputs are combinational from IR and valid DECODE through WB. In FETCH and HALT, `imm_sel`=0 and all selects are 0.
- Watchdog:
  - Counter clears on entering FETCH or MEM.
  - Increments each waiting cycle.
  - Reaching `TIMEOUT` without valid → HALT, `err`=1.
- `ifu_rvalid`/`lsu_rvalid` outside FETCH/MEM respectively are ignored.

## Timing
- Reset: state FETCH, IR=`0x00000013`, counter 0, `br_taken`=0, `halt`=`err`=0. All outputs 0 while `rst` is high. `ifu_req`=1 the first cycle after `rst` falls.
- Minimum latency: 4 cycles for non-memory instructions (rvalid in the first FETCH cycle); 5 cycles for load/store. Each extra memory wait cycle adds 1.
- Requests are held high until the matching valid; the valid and the request may coincide.
- `pc_wen`/`rf_wen` are single-cycle pulses, exactly one per retired instruction.
- `rst` mid-instruction: abort immediately, no WB strobes, return to FETCH; a late `lsu_rvalid` is ignored.
- Timeout fires on the `TIMEOUT`-th consecutive waiting cycle. Valid arriving in that same cycle wins.

## Structure
- Package `ysyx_24070014_ctrl_pkg`:
  - State enum.
  - `imm_sel`, `alu_mode`, `wb_sel` and `pc_sel` encodings.
  - RV opcode constants.
  - `EBREAK` and `NOP` constants.
- Sub-module `ysyx_24070014_ctrl_decoder`: combinational IR → control word plus illegal/ebreak flags.
- The FSM, IR, watchdog and `br_taken` stay in the top.

## Test plan
- Reset release, `ifu_rdata`=`0x00500093` valid in the first FETCH cycle → DECODE `imm_sel`=1, `alu_b_sel`=1, `alu_mode`=2. WB on cycle 4 has `rf_wen`=1, `pc_wen`=1, `pc_sel`=0; then FETCH.
- `0x0000A103` (lw), `lsu_rvalid` after 3 cycles → `lsu_req`=1 for 3 cycles, `lsu_wen`=0, `wb_sel`=1. Store `0x0020A023` → `lsu_wen`=1, `imm_sel`=2, `rf_wen`=0.
- `0x00000463` (beq) with `br_cond`=1 → `imm_sel`=3, WB `pc_sel`=1. With `br_cond`=0 → `pc_sel`=0; `rf_wen`=0 in both cases.
- `0x000080E7` (jalr) → `imm_sel`=1, `pc_sel`=2, `wb_sel`=2. `0x0000006F` (jal) → `imm_sel`=4, `pc_sel`=1.
- `0x00100073` → HALT with `halt`=1, `err`=0, no `pc_wen`. `0xFFFFFFFF` → `err`=1. HALT persists until `rst`.
- `TIMEOUT`=8 with no `ifu_rvalid` → HALT, `err`=1 after 8 FETCH cycles. `rst` during MEM → FETCH next cycle, no strobes, a later `lsu_rvalid` has no effect.
